regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised successor of the single-port integer register file.
- Two independent registered read ports and one write port, so the decode stage can fetch rs1/rs2 in the same cycle.
- Register x0 is hardwired to zero.
- Adds a multi-cycle clear sequencer that software/debug can trigger without asserting reset.

Parameters:
XLEN, 64, data width of each register in bits
NREGS, 32, number of architectural registers including x0; legal range 2..64
(derived, not overridable: ADDR_W = $clog2(NREGS))

Ports:
clk  input  1  all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all registers and outputs
rd_en_a  input  1  capture read port A on this edge
rd_addr_a  input  ADDR_W  register index for port A
rd_data_a  output  XLEN  registered read data, port A
rd_en_b  input  1  capture read port B on this edge
rd_addr_b  input  ADDR_W  register index for port B
rd_data_b  output  XLEN  registered read data, port B
wr_en  input  1  write wr_data to wr_addr on this edge
wr_addr  input  ADDR_W  register index to write
wr_data  input  XLEN  write data
clear  input  1  single-cycle request to start the clear sweep
busy  output  1  high while the clear sweep is in progress

Behaviour:
- Reset (asynchronous, active-high):
  - All registers are 0; rd_data_a = rd_data_b = 0; busy = 0; FSM = IDLE; sweep counter = 0.
  - Reset asserted mid-sweep aborts the sweep. After reset deasserts, the block is in IDLE with all registers zero.
- Read, per port, 1-cycle latency:
  - On the edge where rd_en_x = 1, rd_data_x <= value at rd_addr_x.
  - rd_data_x <= 0 if rd_addr_x == 0, or rd_addr_x >= NREGS, or busy = 1.
  - With rd_en_x = 0, rd_data_x holds its previous value.
  - Ports A and B are fully independent and may read the same address.
- Write:
  - The write takes effect on the edge when wr_en = 1, busy = 0, clear = 0, wr_addr != 0 and wr_addr < NREGS.
  - Otherwise the write is silently dropped; there is no error output.
- Same-edge read and write to the same address: the read returns the old value. Exception: see Optional Feature.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on an edge with clear = 1. The counter loads 1, and busy goes high on the following cycle.
  - In SWEEP, each edge zeroes register[counter] and increments the counter.
  - When counter == NREGS-1, that register is zeroed and the FSM returns to IDLE.
  - busy is high for exactly NREGS-1 cycles.
  - clear asserted while in SWEEP is ignored; the sweep is not restarted.
  - clear and wr_en on the same IDLE edge: clear wins and the write is dropped.
- x0: no storage is required. Every read of x0 returns 0, in every mode.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a same-edge write and read to the same non-zero, in-range address returns wr_data, i.e. write-first forwarding. The forwarding applies only when the write is accepted, so there is no forwarding while busy = 1.
- Undefined: the read returns the pre-write register value, i.e. read-first.
- Both read ports forward independently.

Test Plan:
- Reset then read: pulse reset; read A=x5, B=x31 -> both rd_data = 0; busy = 0.
- Write/read: write x3 = 0xDEAD_BEEF_0000_0001; next cycle read A=x3, B=x3 -> both 0xDEAD_BEEF_0000_0001 one cycle later.
- Same-edge collision:
  - Setup: x7 = 0x11; same edge write x7 = 0x22 and read A=x7.
  - Expected: rd_data_a = 0x11 without the macro, 0x22 with REGFILE_BYPASS_EN.
- x0 tie-off: write x0 = 0xFFFF_FFFF_FFFF_FFFF, then read x0 -> 0; with the macro defined, a same-edge read of x0 -> 0.
- Clear sweep:
  - Setup: fill x1..x31 with index values; pulse clear.
  - Expected: busy high 31 cycles. A write to x4 during busy is dropped, and reads during busy return 0. After busy falls, all registers read 0.
- Reset mid-sweep and hold behaviour:
  - Start the clear sweep, then assert reset at sweep cycle 10 -> busy = 0 immediately.
  - Then write x9 = 0x5 and read with rd_en_a = 1 -> 0x5.
  - Drop rd_en_a for 3 cycles while changing rd_addr_a -> rd_data_a holds 0x5.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Two-read/one-write integer register file with x0 tied to zero and a multi-cycle clear sweep.
// Define REGFILE_BYPASS_EN for write-first forwarding on same-edge read/write collisions.
module regfile_2r1w #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rd_en_a,
    input  logic [$clog2(NREGS)-1:0]        rd_addr_a,
    output logic [XLEN-1:0]                 rd_data_a,
    input  logic                            rd_en_b,
    input  logic [$clog2(NREGS)-1:0]        rd_addr_b,
    output logic [XLEN-1:0]                 rd_data_b,
    input  logic                            wr_en,
    input  logic [$clog2(NREGS)-1:0]        wr_addr,
    input  logic [XLEN-1:0]                 wr_data,
    input  logic                            clear,
    output logic                            busy
);

    localparam int unsigned ADDR_W = $clog2(NREGS);
    localparam int unsigned AW1    = ADDR_W + 1;
    // Array spans the full address space so any index is legal; entries >= NREGS are never written.
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic [XLEN-1:0]     regs [DEPTH];

    logic wr_accept;
    logic clear_start;
    logic rd_ok_a;
    logic rd_ok_b;
    logic fwd_a;
    logic fwd_b;

    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < AW1'(NREGS));
    endfunction

    // Qualify writes, reads and forwarding for this edge.
    always_comb begin
        clear_start = (state == IDLE) && clear;
        wr_accept   = wr_en && !busy && !clear && addr_valid(wr_addr);
        rd_ok_a     = addr_valid(rd_addr_a) && !busy;
        rd_ok_b     = addr_valid(rd_addr_b) && !busy;
`ifdef REGFILE_BYPASS_EN
        fwd_a       = wr_accept && (wr_addr == rd_addr_a);
        fwd_b       = wr_accept && (wr_addr == rd_addr_b);
`else
        fwd_a       = 1'b0;
        fwd_b       = 1'b0;
`endif
    end

    // Clear sequencer: counter walks x1..x(NREGS-1), busy tracks the SWEEP state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state     <= SWEEP;
                        busy      <= 1'b1;
                        sweep_cnt <= ADDR_W'(1);
                    end
                end
                SWEEP: begin
                    if (sweep_cnt == ADDR_W'(NREGS - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    sweep_cnt <= '0;
                end
            endcase
        end
    end

    // Storage: sweep zeroing and accepted writes never coincide because writes require !busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (state == SWEEP) begin
            regs[sweep_cnt] <= '0;
        end else if (wr_accept) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Registered read ports; each holds its value while its enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (rd_en_a) begin
                if (!rd_ok_a)
                    rd_data_a <= '0;
                else if (fwd_a)
                    rd_data_a <= wr_data;
                else
                    rd_data_a <= regs[rd_addr_a];
            end
            if (rd_en_b) begin
                if (!rd_ok_b)
                    rd_data_b <= '0;
                else if (fwd_b)
                    rd_data_b <= wr_data;
                else
                    rd_data_b <= regs[rd_addr_b];
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w (default XLEN=64, NREGS=32).
// Expected collision results follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_2r1w;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned ADDR_W = $clog2(NREGS);

    logic              clk;
    logic              reset;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [XLEN-1:0]   rd_data_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [XLEN-1:0]   rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              clear;
    logic              busy;

    int n_checks;
    int n_fail;

    regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clear     (clear),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] collide_exp;
        int cnt;

        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        rd_en_a   = 1'b0;
        rd_addr_a = '0;
        rd_en_b   = 1'b0;
        rd_addr_b = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clear     = 1'b0;

        step();
        step();
        check("rst_rd_a", rd_data_a, 64'h0);
        check("rst_rd_b", rd_data_b, 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        reset = 1'b0;

        // Reset then read x5 / x31.
        rd_en_a = 1'b1; rd_addr_a = 5'd5;
        rd_en_b = 1'b1; rd_addr_b = 5'd31;
        step();
        check("rd_x5", rd_data_a, 64'h0);
        check("rd_x31", rd_data_b, 64'h0);
        check("busy_idle", 64'(busy), 64'h0);

        // Write then read on both ports.
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD_BEEF_0000_0001;
        step();
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 5'd3;
        rd_en_b = 1'b1; rd_addr_b = 5'd3;
        step();
        check("wr_rd_a_x3", rd_data_a, 64'hDEAD_BEEF_0000_0001);
        check("wr_rd_b_x3", rd_data_b, 64'hDEAD_BEEF_0000_0001);

        // Same-edge collision on x7; port B disabled so it must hold x3.
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h11;
        step();
        wr_data = 64'h22;
        rd_en_a = 1'b1; rd_addr_a = 5'd7;
        step();
`ifdef REGFILE_BYPASS_EN
        collide_exp = 64'h22;
`else
        collide_exp = 64'h11;
`endif
        check("collide_x7", rd_data_a, collide_exp);
        check("hold_b", rd_data_b, 64'hDEAD_BEEF_0000_0001);
        wr_en = 1'b0;
        step();
        check("after_collide_x7", rd_data_a, 64'h22);

        // x0 tie-off: write then read, and same-edge write/read.
        rd_en_a = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 5'd0;
        step();
        check("rd_x0", rd_data_a, 64'h0);
        rd_addr_a = 5'd7;
        step();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_addr_a = 5'd0;
        step();
        wr_en = 1'b0;
        check("same_edge_x0", rd_data_a, 64'h0);

        // Fill x1..x31 with their index, spot-check, then run a clear sweep.
        rd_en_a = 1'b0;
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'(i);
            step();
        end
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 5'd30;
        rd_en_b = 1'b1; rd_addr_b = 5'd4;
        step();
        check("fill_x30", rd_data_a, 64'd30);
        check("fill_x4", rd_data_b, 64'd4);

        rd_en_a = 1'b0; rd_en_b = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 10) begin
                wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h99;
                rd_en_a = 1'b1; rd_addr_a = 5'd20;
            end else if (cnt == 11) begin
                wr_en = 1'b0;
                rd_en_a = 1'b0;
                check("rd_during_busy", rd_data_a, 64'h0);
            end else if (cnt == 15) begin
                clear = 1'b1;
            end else if (cnt == 16) begin
                clear = 1'b0;
            end
            step();
        end
        check("busy_cycles", 64'(cnt), 64'd31);
        check("busy_fell", 64'(busy), 64'h0);
        rd_en_a = 1'b1; rd_en_b = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(32 - i);
            step();
            check($sformatf("swept_a_x%0d", i), rd_data_a, 64'h0);
            check($sformatf("swept_b_x%0d", 32 - i), rd_data_b, 64'h0);
        end

        // Reset at sweep cycle 10 aborts the sweep immediately.
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hABC;
        step();
        wr_en = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 1; i < 10; i++) step();
        check("busy_pre_reset", 64'(busy), 64'h1);
        reset = 1'b1;
        #2;
        check("busy_async_rst", 64'(busy), 64'h0);
        step();
        reset = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 5'd12;
        step();
        check("x12_after_rst", rd_data_a, 64'h0);
        check("busy_after_rst", 64'(busy), 64'h0);

        // Write x9 and read it back, then hold with rd_en_a low.
        rd_en_a = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h5;
        step();
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 5'd9;
        step();
        check("rd_x9", rd_data_a, 64'h5);
        rd_en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_addr_a = 5'(i * 7 + 1);
            step();
            check($sformatf("hold_a_%0d", i), rd_data_a, 64'h5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
